// File: rtl/reference_nco.sv
// Quadrature reference NCO: phase accumulator, quarter-wave sine LUT, amplitude scaling.
// One sample per enabled tick, four-stage pipeline, config via valid/ready handshake.
module reference_nco #(
  parameter int unsigned NUM_BITS   = 24,
  parameter int unsigned PHASE_BITS = 32
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       tick_i,
  input  logic                       enable_i,
  input  logic                       cfg_valid_i,
  output logic                       cfg_ready_o,
  input  logic [PHASE_BITS-1:0]      cfg_freq_i,
  input  logic [23:0]                cfg_amp_i,
  input  logic                       cfg_phase_reset_i,
  output logic signed [NUM_BITS-1:0] sin_o,
  output logic signed [NUM_BITS-1:0] cos_o,
  output logic                       done_o
);

  localparam logic signed [25:0] SatHi = 26'sd8388607;
  localparam logic signed [25:0] SatLo = -26'sd8388607;

  // Evaluated only with constant arguments, so it folds into a ROM.
  function automatic logic [22:0] lut_entry(input int k);
    real v;
    v = 8388607.0 * $sin(2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / 1024.0);
    return 23'($rtoi(v + 0.5));
  endfunction

  function automatic logic signed [25:0] scale(input logic [22:0] mag, input logic neg,
                                               input logic [23:0] amp);
    logic signed [23:0] v;
    logic signed [48:0] prod;
    v    = neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    prod = v * $signed({1'b0, amp});
    return 26'(prod >>> 23);
  endfunction

  function automatic logic signed [23:0] sat(input logic signed [25:0] x);
    if (x > SatHi) return 24'sd8388607;
    if (x < SatLo) return -24'sd8388607;
    return 24'(x);
  endfunction

  logic [22:0] rom [256];
  for (genvar k = 0; k < 256; k++) begin : g_rom
    assign rom[k] = lut_entry(k);
  end

  logic [PHASE_BITS-1:0] acc_q, freq_q, pend_freq_q;
  logic [23:0]           amp_q, pend_amp_q;
  logic                  pend_q, pend_pr_q;
  logic [9:0]            phase_q;
  logic                  v1_q, v2_q, v3_q;
  logic [22:0]           sin_mag_q, cos_mag_q;
  logic                  sin_neg_q, cos_neg_q;
  logic signed [25:0]    sin_prod_q, cos_prod_q;

  logic       tick_en, accept;
  logic [9:0] p_cos;
  logic [7:0] sin_idx, cos_idx;

  assign tick_en = tick_i && enable_i;
  assign accept  = cfg_valid_i && cfg_ready_o;
  assign p_cos   = phase_q + 10'd256;
  // Odd quadrants read the table backwards.
  assign sin_idx = phase_q[8] ? ~phase_q[7:0] : phase_q[7:0];
  assign cos_idx = p_cos[8] ? ~p_cos[7:0] : p_cos[7:0];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q       <= '0;
      freq_q      <= '0;
      amp_q       <= '0;
      pend_freq_q <= '0;
      pend_amp_q  <= '0;
      pend_pr_q   <= 1'b0;
      pend_q      <= 1'b0;
      cfg_ready_o <= 1'b1;
      phase_q     <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      sin_mag_q   <= '0;
      cos_mag_q   <= '0;
      sin_neg_q   <= 1'b0;
      cos_neg_q   <= 1'b0;
      sin_prod_q  <= '0;
      cos_prod_q  <= '0;
      sin_o       <= '0;
      cos_o       <= '0;
      done_o      <= 1'b0;
    end else begin
      v1_q   <= tick_en;
      v2_q   <= v1_q;
      v3_q   <= v2_q;
      done_o <= v3_q;

      if (accept) begin
        pend_q      <= 1'b1;
        pend_freq_q <= cfg_freq_i;
        pend_amp_q  <= cfg_amp_i;
        pend_pr_q   <= cfg_phase_reset_i;
        cfg_ready_o <= 1'b0;
      end

      if (tick_en) begin
        if (pend_q) begin
          freq_q      <= pend_freq_q;
          amp_q       <= pend_amp_q;
          pend_q      <= 1'b0;
          cfg_ready_o <= 1'b1;
          if (pend_pr_q) begin
            phase_q <= '0;
            acc_q   <= pend_freq_q;
          end else begin
            phase_q <= acc_q[PHASE_BITS-1 -: 10];
            acc_q   <= acc_q + pend_freq_q;
          end
        end else begin
          phase_q <= acc_q[PHASE_BITS-1 -: 10];
          acc_q   <= acc_q + freq_q;
        end
      end

      if (v1_q) begin
        sin_mag_q <= rom[sin_idx];
        cos_mag_q <= rom[cos_idx];
        sin_neg_q <= phase_q[9];
        cos_neg_q <= p_cos[9];
      end

      // amp_q is stable here: it only changes on a tick and ticks are >= 5 cycles apart.
      if (v2_q) begin
        sin_prod_q <= scale(sin_mag_q, sin_neg_q, amp_q);
        cos_prod_q <= scale(cos_mag_q, cos_neg_q, amp_q);
      end

      if (v3_q) begin
        sin_o <= NUM_BITS'(sat(sin_prod_q));
        cos_o <= NUM_BITS'(sat(cos_prod_q));
      end
    end
  end

endmodule

// File: tb/tb_reference_nco.sv
// Bench for reference_nco: per-cycle comparison against a tick-level behavioural model,
// plus directed scenarios with literal expectations and randomized traffic.
module tb_reference_nco;
  localparam int NB = 24;
  localparam int PB = 32;

  logic          clk = 1'b1;
  logic          reset = 1'b1, tick = 1'b0, enable = 1'b0, cfg_valid = 1'b0, cfg_pr = 1'b0;
  logic [PB-1:0] cfg_freq = '0;
  logic [23:0]   cfg_amp = '0;
  logic          cfg_ready, done;
  logic signed [NB-1:0] sin_s, cos_s;

  always #5 clk = ~clk;

  reference_nco #(.NUM_BITS(NB), .PHASE_BITS(PB)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .tick_i           (tick),
    .enable_i         (enable),
    .cfg_valid_i      (cfg_valid),
    .cfg_ready_o      (cfg_ready),
    .cfg_freq_i       (cfg_freq),
    .cfg_amp_i        (cfg_amp),
    .cfg_phase_reset_i(cfg_pr),
    .sin_o            (sin_s),
    .cos_o            (cos_s),
    .done_o           (done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  longint ltab [256];

  // Model state, valid after each rising edge.
  logic [PB-1:0] m_acc, m_freq, m_pfreq;
  longint        m_amp, m_pamp, m_sin, m_cos;
  bit            m_pend, m_ppr, m_ready, m_done;
  typedef struct {int left; longint s; longint c;} samp_t;
  samp_t         sq [$];
  bit            started = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Sine of a 10-bit phase from the quarter table, scaled and clamped.
  function automatic longint ref_wave(input int p, input longint amp);
    int     pm;
    longint v;
    pm = p % 512;
    v  = ltab[(pm < 256) ? pm : 511 - pm];
    if (p >= 512) v = -v;
    v = (v * amp) >>> 23;
    if (v > 8388607)  v = 8388607;
    if (v < -8388607) v = -8388607;
    return v;
  endfunction

  task automatic model_step();
    bit    acc_ok;
    int    p;
    samp_t e;
    if (reset) begin
      m_acc = '0; m_freq = '0; m_amp = 0; m_pend = 0; m_ready = 1;
      m_done = 0; m_sin = 0; m_cos = 0;
      sq.delete();
      return;
    end
    m_done = 0;
    for (int i = 0; i < sq.size(); i++) sq[i].left--;
    if (sq.size() > 0 && sq[0].left == 0) begin
      m_sin  = sq[0].s;
      m_cos  = sq[0].c;
      m_done = 1;
      void'(sq.pop_front());
    end
    acc_ok = cfg_valid && m_ready;
    if (tick && enable) begin
      if (m_pend) begin
        m_freq = m_pfreq; m_amp = m_pamp; m_pend = 0; m_ready = 1;
        if (m_ppr) m_acc = '0;
      end
      p      = int'(m_acc >> (PB - 10));
      e.left = 3;
      e.s    = ref_wave(p, m_amp);
      e.c    = ref_wave((p + 256) % 1024, m_amp);
      sq.push_back(e);
      m_acc = m_acc + m_freq;
    end
    if (acc_ok) begin
      m_pend = 1; m_pfreq = cfg_freq; m_pamp = longint'(cfg_amp); m_ppr = cfg_pr; m_ready = 0;
    end
  endtask

  // Compare process: outputs reflect the previous edge; then advance the model for the next.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        check("done_o", done, m_done);
        check("cfg_ready_o", cfg_ready, m_ready);
        check("sin_o", sin_s, m_sin);
        check("cos_o", cos_s, m_cos);
      end
      model_step();
      started = 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_tick(input bit en);
    tick = 1'b1; enable = en;
    cyc(1);
    tick = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit got);
    lat = 0; got = 0;
    for (int i = 1; i <= 8 && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1; lat = i;
      end
    end
    cyc(1);
  endtask

  task automatic tick_and_wait(input string name);
    int lat;
    bit got;
    do_tick(1'b1);
    wait_done(lat, got);
    check({name, " latency"}, lat, 4);
  endtask

  task automatic configure(input logic [PB-1:0] f, input logic [23:0] a, input bit pr);
    bit ok = 0;
    cfg_freq = f; cfg_amp = a; cfg_pr = pr; cfg_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (cfg_ready === 1'b1) ok = 1;
    end
    cyc(1);
    cfg_valid = 1'b0;
    cfg_freq = $urandom; cfg_amp = 24'($urandom); cfg_pr = 1'($urandom);
    check("cfg accepted", ok, 1);
  endtask

  initial begin
    longint exp_s [4];
    longint exp_c [4];
    int     lat;
    bit     got;

    for (int k = 0; k < 256; k++)
      ltab[k] = longint'($rtoi(8388607.0 * $sin(2.0 * 3.14159265358979323846 *
                                                 (real'(k) + 0.5) / 1024.0) + 0.5));
    check("table L[0]", ltab[0], 25736);
    check("table L[255]", ltab[255], 8388568);

    cyc(3);
    check("reset sin", sin_s, 0);
    check("reset cos", cos_s, 0);
    check("reset ready", cfg_ready, 1);
    check("reset done", done, 0);
    reset = 1'b0;
    cyc(2);

    // Unity amplitude, quarter-cycle steps
    configure(32'h4000_0000, 24'd8388608, 1'b1);
    cyc(2);
    exp_s = '{25736, 8388568, -25736, -8388568};
    exp_c = '{8388568, -25736, -8388568, 25736};
    for (int i = 0; i < 4; i++) begin
      tick_and_wait("quarter");
      check("quarter sin", sin_s, exp_s[i]);
      check("quarter cos", cos_s, exp_c[i]);
    end

    // Half amplitude
    configure(32'h4000_0000, 24'd4194304, 1'b1);
    tick_and_wait("half");
    check("half sin", sin_s, 12868);
    check("half cos", cos_s, 4194284);

    // Saturation at both extremes
    configure(32'h3FC0_0000, 24'd16777215, 1'b1);
    tick_and_wait("satp0");
    tick_and_wait("sat255");
    check("sat p255 sin", sin_s, 8388607);
    configure(32'hBFC0_0000, 24'd16777215, 1'b1);
    tick_and_wait("satn0");
    tick_and_wait("sat767");
    check("sat p767 sin", sin_s, -8388607);

    // Accumulator wrap with 3/4-cycle steps
    configure(32'hC000_0000, 24'd8388608, 1'b1);
    exp_s = '{25736, -8388568, -25736, 8388568};
    for (int i = 0; i < 5; i++) begin
      tick_and_wait("wrap");
      check("wrap sin", sin_s, exp_s[i % 4]);
    end

    // Config offered on the same cycle as a tick
    configure(32'h4000_0000, 24'd8388608, 1'b1);
    tick_and_wait("coinc0");
    cfg_freq = 32'h2000_0000; cfg_amp = 24'd8388608; cfg_pr = 1'b0; cfg_valid = 1'b1;
    do_tick(1'b1);
    cfg_valid = 1'b0;
    wait_done(lat, got);
    check("coinc old freq sin", sin_s, 8388568);
    check("coinc ready low", cfg_ready, 0);
    tick_and_wait("coinc apply");
    check("coinc new sin", sin_s, -25736);
    check("coinc ready back", cfg_ready, 1);
    tick_and_wait("coinc next");

    // Reset during T+2
    do_tick(1'b1);
    cyc(1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    wait_done(lat, got);
    check("midreset no done", got, 0);
    check("midreset sin", sin_s, 0);
    check("midreset cos", cos_s, 0);
    check("midreset ready", cfg_ready, 1);

    // Disabled tick leaves a pending config alone
    configure(32'h4000_0000, 24'd8388608, 1'b1);
    do_tick(1'b0);
    wait_done(lat, got);
    check("disabled no done", got, 0);
    check("disabled pending", cfg_ready, 0);
    check("disabled sin", sin_s, 0);
    tick_and_wait("after disabled");
    check("after disabled sin", sin_s, 25736);
    enable = 1'b1;

    // Randomized traffic; the compare process checks every cycle
    for (int it = 0; it < 300; it++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        reset = 1'b1; tick = 1'($urandom); enable = 1'b1; cfg_valid = 1'($urandom);
        cyc(int'($urandom_range(1, 2)));
        reset = 1'b0; tick = 1'b0; cfg_valid = 1'b0;
      end else if (r <= 5) begin
        cfg_freq = $urandom; cfg_amp = 24'($urandom); cfg_pr = 1'($urandom);
        cfg_valid = 1'b1;
        tick = ($urandom_range(0, 3) == 0); enable = 1'($urandom);
        cyc(1);
        cfg_valid = 1'b0; tick = 1'b0;
      end else begin
        do_tick($urandom_range(0, 3) != 0);
      end
      cyc(5 + int'($urandom_range(0, 3)));
    end
    cyc(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
